// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the single memory bus port between instruction fetch (IF) and the
// load/store unit (LS). Each transaction walks IDLE -> REQ -> WAIT -> IDLE.
// A frontend flush drops an in-flight fetch; a starvation guard forces IF to
// win after STARVE_LIMIT back-to-back LS grants taken while IF was waiting.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; arbitrate between eligible requesters
// REQ   | bus_req_valid high, owner's fields on the bus until accepted
// WAIT  | request accepted, waiting for bus_resp_valid
//
// Ports
//   i_clk, i_rst            clock, async active-high reset
//   i_flush                 frontend redirect, kills IF request/response
//   i_if_req_*/o_if_*       fetch request (valid/addr) and ready/response
//   i_ls_req_*/o_ls_*       load/store request (valid/addr/we/wdata/be),
//                           ready and response
//   o_bus_req_*/i_bus_*     bus request fields, bus ready and response
//   o_arb_busy              high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,

    input  logic                i_if_req_valid,
    input  logic [ADDR_W-1:0]   i_if_req_addr,
    output logic                o_if_req_ready,
    output logic                o_if_resp_valid,
    output logic [DATA_W-1:0]   o_if_resp_data,

    input  logic                i_ls_req_valid,
    input  logic [ADDR_W-1:0]   i_ls_req_addr,
    input  logic                i_ls_req_we,
    input  logic [DATA_W-1:0]   i_ls_req_wdata,
    input  logic [DATA_W/8-1:0] i_ls_req_be,
    output logic                o_ls_req_ready,
    output logic                o_ls_resp_valid,
    output logic [DATA_W-1:0]   o_ls_resp_data,

    output logic                o_bus_req_valid,
    output logic [ADDR_W-1:0]   o_bus_req_addr,
    output logic                o_bus_req_we,
    output logic [DATA_W-1:0]   o_bus_req_wdata,
    output logic [DATA_W/8-1:0] o_bus_req_be,
    input  logic                i_bus_req_ready,
    input  logic                i_bus_resp_valid,
    input  logic [DATA_W-1:0]   i_bus_resp_data,

    output logic                o_arb_busy
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);
    localparam logic       OWNER_IF = 1'b0;
    localparam logic       OWNER_LS = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_drop;
    logic [2:0] r_starve_cnt;

    logic w_if_elig;
    logic w_ls_elig;
    logic w_grant_if;

    // A fetch raised in the same cycle as a flush is already stale.
    assign w_if_elig  = i_if_req_valid & ~i_flush;
    assign w_ls_elig  = i_ls_req_valid;
    // LS has priority unless IF has been passed over STARVE_LIMIT times.
    assign w_grant_if = w_if_elig & (~w_ls_elig | (r_starve_cnt == LIMIT));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWNER_IF;
            r_drop       <= 1'b0;
            r_starve_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_if_elig || w_ls_elig) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                        r_owner <= w_grant_if ? OWNER_IF : OWNER_LS;
                        if (w_grant_if) begin
                            r_starve_cnt <= 3'd0;
                        end else if (w_if_elig && (r_starve_cnt < LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end
                end
                S_REQ: begin
                    // The bus request cannot be retracted, so a flushed fetch
                    // still runs to completion but is marked for discard.
                    if ((r_owner == OWNER_IF) && i_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (i_bus_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if ((r_owner == OWNER_IF) && i_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (i_bus_resp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so that an async reset clears them
    // in the same cycle.
    always_comb begin
        o_if_req_ready  = 1'b0;
        o_if_resp_valid = 1'b0;
        o_if_resp_data  = '0;
        o_ls_req_ready  = 1'b0;
        o_ls_resp_valid = 1'b0;
        o_ls_resp_data  = '0;
        o_bus_req_valid = 1'b0;
        o_bus_req_addr  = '0;
        o_bus_req_we    = 1'b0;
        o_bus_req_wdata = '0;
        o_bus_req_be    = '0;
        o_arb_busy      = (r_state != S_IDLE);

        if (r_state == S_REQ) begin
            o_bus_req_valid = 1'b1;
            if (r_owner == OWNER_LS) begin
                o_bus_req_addr  = i_ls_req_addr;
                o_bus_req_we    = i_ls_req_we;
                o_bus_req_wdata = i_ls_req_wdata;
                o_bus_req_be    = i_ls_req_be;
                o_ls_req_ready  = i_bus_req_ready;
            end else begin
                o_bus_req_addr  = i_if_req_addr;
                o_bus_req_be    = {BE_W{1'b1}};
                // Withholding ready keeps the frontend's request pending so
                // it is re-issued once the flushed transaction drains.
                o_if_req_ready  = i_bus_req_ready & ~r_drop & ~i_flush;
            end
        end

        if ((r_state == S_WAIT) && i_bus_resp_valid) begin
            if (r_owner == OWNER_LS) begin
                o_ls_resp_valid = 1'b1;
                o_ls_resp_data  = i_bus_resp_data;
            end else if (!r_drop && !i_flush) begin
                o_if_resp_valid = 1'b1;
                o_if_resp_data  = i_bus_resp_data;
            end
        end
    end

    // Requesters must hold valid until accepted. A flushed fetch may be
    // withdrawn, since the frontend is redirecting.
    a_ls_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_ls_req_valid && !o_ls_req_ready) |=> i_ls_req_valid);

    a_if_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_if_req_valid && !o_if_req_ready && !i_flush) |=> i_if_req_valid);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int LIMIT  = 4;

    typedef struct {
        logic        owner;   // 0 = IF, 1 = LS
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ph;      // flush plan: 0 none, 1 during REQ, 2 during WAIT
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              if_req_valid = 1'b0;
    logic [31:0]       if_req_addr  = '0;
    logic              ls_req_valid = 1'b0;
    logic [31:0]       ls_req_addr  = '0;
    logic              ls_req_we    = 1'b0;
    logic [31:0]       ls_req_wdata = '0;
    logic [3:0]        ls_req_be    = '0;

    logic              bus_auto = 1'b0;
    logic              rsp_ready = 1'b0, rsp_resp_valid = 1'b0, rsp_flush = 1'b0;
    logic [31:0]       rsp_data = '0;
    logic              dir_ready = 1'b0, dir_resp_valid = 1'b0;
    logic [31:0]       dir_resp_data = '0;

    logic              flush, bus_req_ready, bus_resp_valid;
    logic [31:0]       bus_resp_data;
    assign flush          = bus_auto & rsp_flush;
    assign bus_req_ready  = bus_auto ? rsp_ready      : dir_ready;
    assign bus_resp_valid = bus_auto ? rsp_resp_valid : dir_resp_valid;
    assign bus_resp_data  = bus_auto ? rsp_data       : dir_resp_data;

    logic              o_if_req_ready, o_if_resp_valid;
    logic [31:0]       o_if_resp_data;
    logic              o_ls_req_ready, o_ls_resp_valid;
    logic [31:0]       o_ls_resp_data;
    logic              o_bus_req_valid, o_bus_req_we, o_arb_busy;
    logic [31:0]       o_bus_req_addr, o_bus_req_wdata;
    logic [3:0]        o_bus_req_be;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_if_req_valid(if_req_valid), .i_if_req_addr(if_req_addr),
        .o_if_req_ready(o_if_req_ready), .o_if_resp_valid(o_if_resp_valid),
        .o_if_resp_data(o_if_resp_data),
        .i_ls_req_valid(ls_req_valid), .i_ls_req_addr(ls_req_addr),
        .i_ls_req_we(ls_req_we), .i_ls_req_wdata(ls_req_wdata), .i_ls_req_be(ls_req_be),
        .o_ls_req_ready(o_ls_req_ready), .o_ls_resp_valid(o_ls_resp_valid),
        .o_ls_resp_data(o_ls_resp_data),
        .o_bus_req_valid(o_bus_req_valid), .o_bus_req_addr(o_bus_req_addr),
        .o_bus_req_we(o_bus_req_we), .o_bus_req_wdata(o_bus_req_wdata),
        .o_bus_req_be(o_bus_req_be),
        .i_bus_req_ready(bus_req_ready), .i_bus_resp_valid(bus_resp_valid),
        .i_bus_resp_data(bus_resp_data),
        .o_arb_busy(o_arb_busy)
    );

    txn_t        exp_bus[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_ls[$];
    txn_t        ls_ops[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_starve = 0;   // LS grants taken while IF was waiting

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory contents seen by the bus model: a fixed function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    // Bus model: random accept and response latency, optional flush pulse
    // placed as the head of the expected-transaction queue asks.
    initial begin : responder
        int          ph, da, dr, fa, fr;
        logic [31:0] a;
        forever begin
            @(posedge clk); #1;
            rsp_ready = 1'b0; rsp_resp_valid = 1'b0; rsp_flush = 1'b0; rsp_data = $urandom;
            if (bus_auto && !rst && o_bus_req_valid) begin
                ph = (exp_bus.size() > 0) ? exp_bus[0].ph : 0;
                a  = o_bus_req_addr;
                da = $urandom_range(0, 2);
                dr = $urandom_range(0, 2);
                fa = $urandom_range(0, da);
                fr = $urandom_range(0, dr);
                for (int i = 0; i <= da; i++) begin
                    if (i > 0) begin @(posedge clk); #1; end
                    rsp_ready = (i == da);
                    rsp_flush = (ph == 1) && (i == fa);
                    rsp_data  = $urandom;
                end
                for (int i = 0; i <= dr; i++) begin
                    @(posedge clk); #1;
                    rsp_ready      = 1'b0;
                    rsp_flush      = (ph == 2) && (i == fr);
                    rsp_resp_valid = (i == dr);
                    rsp_data       = (i == dr) ? mem_f(a) : $urandom;
                end
            end
        end
    end

    initial begin : monitor
        txn_t        t;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_bus_req_valid && bus_req_ready) begin
                    if (exp_bus.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL bus_unexpected: got transaction addr %0h, expected none", o_bus_req_addr);
                    end else begin
                        t = exp_bus.pop_front();
                        chk("bus_addr",     o_bus_req_addr,  t.addr);
                        chk("bus_we",       o_bus_req_we,    t.we);
                        chk("bus_wdata",    o_bus_req_wdata, t.wdata);
                        chk("bus_be",       o_bus_req_be,    t.be);
                        chk("if_req_ready", o_if_req_ready,  (t.owner == 1'b0) && (t.ph != 1));
                        chk("ls_req_ready", o_ls_req_ready,  t.owner);
                    end
                end else begin
                    chk("if_req_ready_quiet", o_if_req_ready, 1'b0);
                    chk("ls_req_ready_quiet", o_ls_req_ready, 1'b0);
                    if (!o_bus_req_valid) chk("bus_addr_idle", o_bus_req_addr, 32'h0);
                end
                if (o_if_resp_valid) begin
                    if (exp_if.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL if_resp_unexpected: got data %0h, expected no response", o_if_resp_data);
                    end else begin
                        d = exp_if.pop_front();
                        chk("if_resp_data", o_if_resp_data, d);
                    end
                end else chk("if_resp_data_idle", o_if_resp_data, 32'h0);
                if (o_ls_resp_valid) begin
                    if (exp_ls.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL ls_resp_unexpected: got data %0h, expected no response", o_ls_resp_data);
                    end else begin
                        d = exp_ls.pop_front();
                        chk("ls_resp_data", o_ls_resp_data, d);
                    end
                end else chk("ls_resp_data_idle", o_ls_resp_data, 32'h0);
            end
        end
    end

    task automatic drive_if(input logic [31:0] a);
        int n;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_if_req_ready && n < 400);
        chk("if_ready_seen", o_if_req_ready, 1'b1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
    endtask

    task automatic drive_ls();
        int n;
        for (int j = 0; j < ls_ops.size(); j++) begin
            @(posedge clk); #1;
            ls_req_valid = 1'b1;
            ls_req_addr  = ls_ops[j].addr;
            ls_req_we    = ls_ops[j].we;
            ls_req_wdata = ls_ops[j].wdata;
            ls_req_be    = ls_ops[j].be;
            n = 0;
            do begin @(negedge clk); n++; end while (!o_ls_req_ready && n < 400);
            chk("ls_ready_seen", o_ls_req_ready, 1'b1);
        end
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
    endtask

    // kind: 0 IF only, 1 LS only, 2 both at once. k = number of back-to-back
    // LS ops. ph < 0 picks flush plans at random.
    task automatic run_episode(input int kind, input int k, input int ph, input bit first_store);
        txn_t        t;
        logic [31:0] tmp, ia;
        int          iph, if_left, li, n;
        bit          has_if;
        has_if = (kind != 1);
        tmp = $urandom; ia = tmp & 32'hFFFF_FFFC;
        if (ph >= 0) iph = ph;
        else begin n = $urandom_range(0, 3); iph = (n < 2) ? 0 : n - 1; end
        ls_ops.delete();
        for (int j = 0; j < k; j++) begin
            tmp     = $urandom;
            t.owner = 1'b1;
            t.addr  = tmp & 32'hFFFF_FFFC;
            t.we    = 1'($urandom_range(0, 1));
            t.wdata = $urandom;
            t.be    = 4'($urandom_range(0, 15));
            t.ph    = (ph >= 0) ? ph : $urandom_range(0, 2);
            if (first_store && j == 0) begin
                t.we = 1'b1; t.be = 4'hF; t.wdata = 32'hDEAD_BEEF;
            end
            ls_ops.push_back(t);
        end
        // Reference grant order: LS wins a contested grant unless IF has
        // already been passed over LIMIT times; a fetch flushed before
        // acceptance stays pending and is fetched again.
        if_left = has_if ? ((iph == 1) ? 2 : 1) : 0;
        li = 0;
        while (if_left > 0 || li < k) begin
            if (if_left > 0 && (li >= k || m_starve == LIMIT)) begin
                t.owner = 1'b0; t.addr = ia; t.we = 1'b0; t.wdata = 32'h0; t.be = 4'hF;
                t.ph    = (if_left == 2) ? 1 : ((iph == 1) ? 0 : iph);
                exp_bus.push_back(t);
                if (t.ph == 0) exp_if.push_back(mem_f(ia));
                m_starve = 0;
                if_left--;
            end else begin
                if (if_left > 0 && m_starve < LIMIT) m_starve++;
                exp_bus.push_back(ls_ops[li]);
                exp_ls.push_back(mem_f(ls_ops[li].addr));
                li++;
            end
        end
        fork
            begin if (has_if) drive_if(ia); end
            begin if (k > 0) drive_ls(); end
        join
        n = 0;
        while ((exp_bus.size() + exp_if.size() + exp_ls.size()) > 0 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("episode_outstanding", exp_bus.size() + exp_if.size() + exp_ls.size(), 0);
        exp_bus.delete(); exp_if.delete(); exp_ls.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        txn_t t;
        int   kind, k;

        // Reset values while rst is held.
        #12;
        chk("rst_bus_valid", o_bus_req_valid, 1'b0);
        chk("rst_busy",      o_arb_busy,      1'b0);
        chk("rst_if_ready",  o_if_req_ready,  1'b0);
        chk("rst_if_resp",   o_if_resp_valid, 1'b0);
        chk("rst_ls_ready",  o_ls_req_ready,  1'b0);
        chk("rst_ls_resp",   o_ls_resp_valid, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single fetch with a zero-latency bus: exact cycle timing.
        t.owner = 1'b0; t.addr = 32'h8000_0000; t.we = 1'b0; t.wdata = 32'h0; t.be = 4'hF; t.ph = 0;
        exp_bus.push_back(t);
        exp_if.push_back(32'h0000_0013);
        @(posedge clk); #1; if_req_valid = 1'b1; if_req_addr = 32'h8000_0000;
        @(negedge clk); chk("t1_bus_valid_N", o_bus_req_valid, 1'b0);
        @(posedge clk); #1; dir_ready = 1'b1;
        @(negedge clk);
        chk("t1_bus_valid_N1", o_bus_req_valid, 1'b1);
        chk("t1_if_ready_N1",  o_if_req_ready,  1'b1);
        @(posedge clk); #1;
        dir_ready = 1'b0; if_req_valid = 1'b0; dir_resp_valid = 1'b1; dir_resp_data = 32'h0000_0013;
        @(negedge clk);
        chk("t1_if_resp_N2", o_if_resp_valid, 1'b1);
        chk("t1_if_data_N2", o_if_resp_data,  32'h0000_0013);
        @(posedge clk); #1; dir_resp_valid = 1'b0;
        @(negedge clk); chk("t1_busy_N3", o_arb_busy, 1'b0);
        repeat (2) @(posedge clk);

        bus_auto = 1'b1;
        run_episode(2, 1, 0, 1'b1);   // contested: store first, then fetch
        run_episode(2, 6, 0, 1'b0);   // LS stream: IF forced in after LIMIT grants
        run_episode(0, 0, 1, 1'b0);   // fetch flushed before acceptance
        run_episode(0, 0, 2, 1'b0);   // fetch flushed while waiting
        run_episode(0, 0, 0, 1'b0);   // next fetch unaffected
        run_episode(1, 1, 2, 1'b0);   // flush during LS wait
        run_episode(1, 1, 1, 1'b0);   // flush during LS request
        run_episode(2, 7, 1, 1'b0);   // flushed fetch inside an LS stream
        for (int e = 0; e < 40; e++) begin
            kind = $urandom_range(0, 2);
            k    = (kind == 0) ? 0 : (kind == 1) ? $urandom_range(1, 3) : $urandom_range(1, 7);
            run_episode(kind, k, -1, 1'b0);
        end

        // Reset in WAIT: outputs clear immediately; a late response is ignored.
        bus_auto = 1'b0;
        t.owner = 1'b0; t.addr = 32'h0000_4000; t.we = 1'b0; t.wdata = 32'h0; t.be = 4'hF; t.ph = 0;
        exp_bus.push_back(t);
        @(posedge clk); #1; if_req_valid = 1'b1; if_req_addr = 32'h0000_4000;
        @(posedge clk); #1; dir_ready = 1'b1;
        @(posedge clk); #1; dir_ready = 1'b0; if_req_valid = 1'b0;
        @(negedge clk); chk("rw_busy_wait", o_arb_busy, 1'b1);
        #1; rst = 1'b1; dir_resp_valid = 1'b1; dir_resp_data = 32'h0000_1234;
        #1;
        chk("rw_busy_async",     o_arb_busy,      1'b0);
        chk("rw_bus_valid",      o_bus_req_valid, 1'b0);
        chk("rw_if_resp_async",  o_if_resp_valid, 1'b0);
        chk("rw_if_data_async",  o_if_resp_data,  32'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rw_late_if_resp", o_if_resp_valid, 1'b0);
        chk("rw_late_ls_resp", o_ls_resp_valid, 1'b0);
        chk("rw_late_busy",    o_arb_busy,      1'b0);
        @(posedge clk); #1; dir_resp_valid = 1'b0;
        exp_bus.delete();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the single memory bus port between the frontend instruction-fetch requester (IF) and the backend load/store unit (LS). Sequences each transaction through request, accept and response phases, and drops in-flight fetch responses on pipeline flush. Includes a starvation guard so a long run of memory operations cannot lock out fetch. Sits between the frontend/backend pair and the bus, owning the bus request and response signals.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive LS grants while IF waits before IF is forced to win (1..7)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  frontend redirect; invalidates any IF request or response
- if_req_valid  in  1  fetch request, held with if_req_addr until if_req_ready
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  one-cycle pulse: fetch accepted by bus
- if_resp_valid  out  1  one-cycle pulse: fetch data valid
- if_resp_data  out  DATA_W  fetch data
- ls_req_valid  in  1  LS request, held with all ls_req_* until ls_req_ready
- ls_req_addr  in  ADDR_W  LS address
- ls_req_we  in  1  1 = store
- ls_req_wdata  in  DATA_W  store data
- ls_req_be  in  DATA_W/8  byte enables
- ls_req_ready  out  1  one-cycle pulse: LS accepted
- ls_resp_valid  out  1  one-cycle pulse: LS complete (load data or store ack)
- ls_resp_data  out  DATA_W  load data
- bus_req_valid  out  1  request to bus
- bus_req_addr, bus_req_we, bus_req_wdata, bus_req_be  out  ADDR_W/1/DATA_W/DATA_W/8  muxed from owner; IF forces we=0, be=all ones, wdata=0
- bus_req_ready  in  1  bus accepts request this cycle
- bus_resp_valid  in  1  bus response this cycle
- bus_resp_data  in  DATA_W  response data
- arb_busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT. Registers: state, owner (0=IF, 1=LS), drop, starve_cnt (3-bit).
- IDLE: IF eligible = if_req_valid & ~flush. If only one eligible, grant it. If both: LS wins unless starve_cnt == STARVE_LIMIT, then IF. On grant: owner latched, state -> REQ, drop <= 0. None eligible: stay.
- starve_cnt: on LS grant while IF eligible, increment (saturate at STARVE_LIMIT); on IF grant, clear to 0; otherwise hold.
- REQ: bus_req_valid = 1, fields muxed combinationally from owner's inputs. When bus_req_ready: owner's *_req_ready pulses (combinational from bus_req_ready), state -> WAIT.
- WAIT: on bus_resp_valid: state -> IDLE; owner's resp_valid = ~drop (IF) / 1 (LS), resp_data = bus_resp_data (combinational).
- Flush: if owner = IF and flush asserted in REQ or WAIT, drop <= 1. In REQ the bus request is still held until accepted (bus protocol forbids retracting); if_req_ready is suppressed when drop or flush. In WAIT the response is consumed and not forwarded. Flush never affects an LS transaction.
- All outputs not named above are 0 in every state; if_resp_data/ls_resp_data = 0 when their valid is 0.

## Timing
- Reset (async, immediate): state=IDLE, owner=0, drop=0, starve_cnt=0; all outputs 0.
- Grant evaluated cycle N (IDLE) -> bus_req_valid at N+1; ready pulse same cycle as bus_req_ready; response forwarded same cycle as bus_resp_valid; next grant earliest cycle after response (IDLE re-entered). Minimum transaction: 3 cycles, 0-latency bus.
- bus_req_ready and bus_resp_valid in the same REQ cycle: the response is ignored; the bus never responds before acceptance.
- Reset mid-transaction: bus_req_valid drops asynchronously; outstanding response discarded.
- Requester deasserting valid before ready is illegal; checked by assertion.

## Test plan
- Single IF fetch, addr 0x8000_0000, bus ready at N+1, resp 0x0000_0013 at N+2 -> if_req_ready pulse N+1, if_resp_valid with 0x13 at N+2, arb_busy low at N+3.
- IF and LS valid simultaneously, starve_cnt=0 -> LS granted first (store, be=0xF, wdata 0xDEADBEEF on bus), IF granted next; starve_cnt 1 then 0.
- LS held valid continuously with IF valid, STARVE_LIMIT=4 -> 4 LS grants, 5th grant to IF, counter clears.
- IF in WAIT, flush pulse, bus resp 0x1234 -> no if_resp_valid, state IDLE; next IF grant proceeds normally.
- IF in REQ with bus_req_ready low, flush -> bus_req_valid held, if_req_ready suppressed when bus accepts, response dropped; LS in WAIT with flush -> ls_resp_valid still delivered.
- Assert rst during WAIT -> all outputs 0 same cycle, state IDLE, late bus_resp_valid produces no resp pulse.
